// File: rtl/freq_meter.sv
// rtl/freq_meter.sv - gated frequency counter: counts synchronized sig_in rising edges per gate window
module freq_meter #(
  parameter int GATE_CYCLES = 100000
) (
  input  logic        clk_100kHz,
  input  logic        rst_,
  input  logic        en,
  input  logic        sig_in,
  output logic [31:0] freq_meas,
  output logic        meas_valid,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    GATE
  } state_t;

  localparam logic [23:0] LAST_CNT = 24'(GATE_CYCLES - 1);

  state_t      state;
  state_t      state_nxt;
  logic        sync1;
  logic        sync2;
  logic        hist;
  logic        rise;
  logic        terminal;
  logic [31:0] edge_cnt;
  logic [31:0] edge_inc;
  logic [23:0] gate_cnt;

  // sig_in is asynchronous: two flops for metastability, a third to find the edge
  always_ff @(posedge clk_100kHz) begin
    if (!rst_) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      hist  <= 1'b0;
    end else begin
      sync1 <= sig_in;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  assign rise     = sync2 & ~hist;
  assign terminal = (state == GATE) && (gate_cnt == LAST_CNT);
  assign edge_inc = (rise && (edge_cnt != 32'hFFFF_FFFF)) ? edge_cnt + 32'd1 : edge_cnt;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk_100kHz) begin
    if (!rst_) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (en) begin
          state_nxt = ARM;
        end
      end
      ARM: begin
        state_nxt = GATE;
      end
      GATE: begin
        if (terminal) begin
          state_nxt = en ? GATE : IDLE;
        end else if (!en) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // The rise seen in the terminal cycle still belongs to the closing window
  always_ff @(posedge clk_100kHz) begin
    if (!rst_) begin
      edge_cnt   <= 32'd0;
      gate_cnt   <= 24'd0;
      freq_meas  <= 32'd0;
      meas_valid <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      case (state)
        ARM: begin
          edge_cnt <= 32'd0;
          gate_cnt <= 24'd0;
        end
        GATE: begin
          if (terminal) begin
            freq_meas  <= edge_inc;
            meas_valid <= 1'b1;
            edge_cnt   <= 32'd0;
            gate_cnt   <= 24'd0;
          end else if (en) begin
            edge_cnt <= edge_inc;
            gate_cnt <= gate_cnt + 24'd1;
          end else begin
            edge_cnt <= 32'd0;
            gate_cnt <= 24'd0;
          end
        end
        default: begin
          edge_cnt <= edge_cnt;
          gate_cnt <= gate_cnt;
        end
      endcase
    end
  end

endmodule
